// File: rtl/hct138_decoder.sv
// Registered 74HCT138-style 3-to-8 decoder with active-low outputs and an alarm buzzer.
// Optional tone mode: define HCT138_BUZZER_TONE_EN to make Buzzer a square wave of half-period TONE_DIV.
module hct138_decoder #(
  parameter int unsigned TONE_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic G,
  input  logic G_2A,
  input  logic G_2B,
  output logic Y0,
  output logic Y1,
  output logic Y2,
  output logic Y3,
  output logic Y4,
  output logic Y5,
  output logic Y6,
  output logic Y7,
  output logic Buzzer
);

  if (TONE_DIV < 1 || TONE_DIV > 65535) begin : g_bad_tone_div
    $error("hct138_decoder: TONE_DIV must be in 1..65535");
  end

  logic       en;
  logic [2:0] addr;
  logic       alarm;
  logic [7:0] y_next;
  logic [7:0] y_q;
  logic       buzzer_q;

  assign en    = G & ~G_2A & ~G_2B;
  assign addr  = {C, B, A};
  assign alarm = en & (addr == 3'd7);

  always_comb begin
    y_next = '1;
    if (en) begin
      y_next[addr] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '1;
    end else begin
      y_q <= y_next;
    end
  end

`ifdef HCT138_BUZZER_TONE_EN
  logic [15:0] tone_cnt;
  logic        tone_active;

  // The first sampled alarm starts a fresh high phase; the counter then
  // toggles the phase every TONE_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_cnt    <= '0;
      tone_active <= 1'b0;
      buzzer_q    <= 1'b0;
    end else if (!alarm) begin
      tone_cnt    <= '0;
      tone_active <= 1'b0;
      buzzer_q    <= 1'b0;
    end else if (!tone_active) begin
      tone_cnt    <= '0;
      tone_active <= 1'b1;
      buzzer_q    <= 1'b1;
    end else if (tone_cnt == 16'(TONE_DIV - 1)) begin
      tone_cnt <= '0;
      buzzer_q <= ~buzzer_q;
    end else begin
      tone_cnt <= tone_cnt + 16'd1;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buzzer_q <= 1'b0;
    end else begin
      buzzer_q <= alarm;
    end
  end
`endif

  assign Y0     = y_q[0];
  assign Y1     = y_q[1];
  assign Y2     = y_q[2];
  assign Y3     = y_q[3];
  assign Y4     = y_q[4];
  assign Y5     = y_q[5];
  assign Y6     = y_q[6];
  assign Y7     = y_q[7];
  assign Buzzer = buzzer_q;

endmodule

// File: tb/tb_hct138_decoder.sv
// Directed self-checking bench for hct138_decoder (checks tone behaviour when HCT138_BUZZER_TONE_EN is defined).
module tb_hct138_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic A = 1'b0, B = 1'b0, C = 1'b0;
  logic G = 1'b0, G_2A = 1'b0, G_2B = 1'b0;
  logic Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, Buzzer;
  logic [7:0] y;

  int checks = 0;
  int errors = 0;

  assign y = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};

  always #5 clk = ~clk;

  hct138_decoder #(.TONE_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .A(A), .B(B), .C(C),
    .G(G), .G_2A(G_2A), .G_2B(G_2B),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
    .Y4(Y4), .Y5(Y5), .Y6(Y6), .Y7(Y7),
    .Buzzer(Buzzer)
  );

  task automatic check_y(input string tag, input logic [7:0] exp);
    checks++;
    assert (y === exp) else begin
      errors++;
      $error("FAIL %s Y=%b expected %b", tag, y, exp);
    end
  endtask

  task automatic check_bz(input string tag, input logic exp);
    checks++;
    assert (Buzzer === exp) else begin
      errors++;
      $error("FAIL %s Buzzer=%b expected %b", tag, Buzzer, exp);
    end
  endtask

  task automatic set_addr(input int unsigned n);
    logic [2:0] a3;
    a3 = 3'(n);
    {C, B, A} = a3;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] e;
    logic       bz;

    // Reset with an enabled address 3: outputs forced before any clock edge.
    G = 1'b1; G_2A = 1'b0; G_2B = 1'b0;
    set_addr(3);
    #1 rst = 1'b1;
    #1;
    check_y("reset_async_y", 8'hFF);
    check_bz("reset_async_bz", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step;
    check_y("after_reset_addr3", 8'b1111_0111);

    // Sweep 0..7 then wrap to 0.
    for (int n = 0; n < 9; n++) begin
      set_addr(n % 8);
      step;
      e = ~(8'd1 << (n % 8));
      check_y($sformatf("sweep_%0d", n), e);
      check_bz($sformatf("sweep_bz_%0d", n), (n % 8) == 7);
    end

    // Enable gating with addr 2.
    set_addr(2);
    G = 1'b0; G_2A = 1'b0; G_2B = 1'b0;
    step;
    check_y("gate_g0", 8'hFF);
    check_bz("gate_g0_bz", 1'b0);
    G = 1'b1; G_2A = 1'b1; G_2B = 1'b0;
    step;
    check_y("gate_g2a", 8'hFF);
    check_bz("gate_g2a_bz", 1'b0);
    G = 1'b1; G_2A = 1'b0; G_2B = 1'b1;
    step;
    check_y("gate_g2b", 8'hFF);
    check_bz("gate_g2b_bz", 1'b0);
    // Disabled with alarm address must not sound.
    set_addr(7);
    step;
    check_y("gate_addr7", 8'hFF);
    check_bz("gate_addr7_bz", 1'b0);

    // Alarm address, then move to 6.
    G_2B = 1'b0;
    set_addr(7);
    step;
    check_y("alarm_y7", 8'b0111_1111);
    check_bz("alarm_bz_on", 1'b1);
    set_addr(6);
    step;
    check_y("alarm_to_y6", 8'b1011_1111);
    check_bz("alarm_bz_off", 1'b0);

    // Hold alarm for 20 cycles.
    set_addr(7);
    for (int k = 0; k < 20; k++) begin
      step;
`ifdef HCT138_BUZZER_TONE_EN
      bz = ((k / 4) % 2) == 0;
`else
      bz = 1'b1;
`endif
      check_bz($sformatf("hold_bz_%0d", k), bz);
      check_y($sformatf("hold_y_%0d", k), 8'b0111_1111);
    end
    G = 1'b0;
    step;
    check_bz("drop_g_bz", 1'b0);
    check_y("drop_g_y", 8'hFF);

    // Async reset mid-alarm, between edges.
    G = 1'b1;
    step;
    check_bz("pre_rst_bz", 1'b1);
    #2 rst = 1'b1;
    #1;
    check_y("mid_rst_y", 8'hFF);
    check_bz("mid_rst_bz", 1'b0);
    #1 rst = 1'b0;
    step;
    check_y("post_rst_y", 8'b0111_1111);
    check_bz("post_rst_bz", 1'b1);
    step;
    check_bz("post_rst_bz2", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
